// File: rtl/drum_pkg.sv
// Shared widths and saturation helper for the drum simulator datapath.
// Used by column_simulation, ComputeModule_for_col and drum_audio_tap.
package drum_pkg;

    localparam int Q1_17_W     = 18;
    localparam int PCM_W       = 16;
    localparam int ROW_W       = 6;
    localparam int NUM_ROW_DEF = 33;
    localparam int SCALE_W     = 26;

    localparam logic signed [SCALE_W-1:0] SAT_MAX = 26'sd131071;
    localparam logic signed [SCALE_W-1:0] SAT_MIN = -26'sd131072;

    // Clamp a widened amplitude back into the signed 1.17 range.
    function automatic logic signed [Q1_17_W-1:0] sat18(input logic signed [SCALE_W-1:0] s);
        if (s > SAT_MAX) begin
            return 18'sh1FFFF;
        end else if (s < SAT_MIN) begin
            return 18'sh20000;
        end else begin
            return s[Q1_17_W-1:0];
        end
    endfunction

endpackage

// File: rtl/drum_audio_tap_if.sv
// Audio sample bus: the tap drives data/valid, the bus master returns ready.
interface drum_audio_tap_if;

    logic [drum_pkg::PCM_W-1:0] audio_data;
    logic                       audio_valid;
    logic                       audio_ready;

    modport master (output audio_data, output audio_valid, input audio_ready);
    modport slave  (input audio_data, input audio_valid, output audio_ready);

endinterface

// File: rtl/drum_audio_tap_sync_fifo.sv
// Synchronous FIFO with occupancy count; a push on a full FIFO is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Head is read combinationally, so a same-cycle write at the head slot
    // (full with pop) still hands out the old entry.
    assign dout = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/drum_audio_tap.sv
// Samples the tap node once per simulation step, scales it to saturated PCM,
// buffers it and streams it out on a valid/ready bus with back-pressure.
module drum_audio_tap
    import drum_pkg::*;
#(
    parameter int NUM_ROW    = NUM_ROW_DEF,
    parameter int TAP_ROW    = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int GAIN_SHIFT = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [Q1_17_W-1:0] u_np1_ij,
    input  logic [ROW_W-1:0]          row,
    input  logic                      u_valid,
    input  logic                      step_done,
    drum_audio_tap_if.master          audio,
    output logic                      sim_stall,
    output logic                      overflow
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_LOAD  = 1'b1;

    logic                      tap_hit;
    logic signed [Q1_17_W-1:0] tap_reg;
    logic signed [Q1_17_W-1:0] tap_src;
    logic signed [SCALE_W-1:0] tap_ext;
    logic signed [SCALE_W-1:0] scaled;
    logic signed [Q1_17_W-1:0] s_sat;
    logic [PCM_W-1:0]          pcm;

    logic [PCM_W-1:0] fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic             fifo_pop;

    logic [0:0]       state;
    logic [PCM_W-1:0] data_reg;
    logic             valid_reg;

    assign tap_hit = u_valid && (row == ROW_W'(TAP_ROW)) && (32'(row) < NUM_ROW);

    // A tap write coincident with step_done bypasses tap_reg so the fresh value is pushed.
    assign tap_src = tap_hit ? u_np1_ij : tap_reg;
    assign tap_ext = {{(SCALE_W-Q1_17_W){tap_src[Q1_17_W-1]}}, tap_src};
    assign scaled  = tap_ext <<< GAIN_SHIFT;
    assign s_sat   = sat18(scaled);
    assign pcm     = PCM_W'(s_sat >>> 2);

    always_ff @(posedge clk) begin
        if (rst) begin
            tap_reg <= '0;
        end else if (tap_hit) begin
            tap_reg <= u_np1_ij;
        end
    end

    sync_fifo #(
        .WIDTH (PCM_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (step_done),
        .din   (pcm),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign fifo_pop = !fifo_empty && ((state == ST_EMPTY) || (valid_reg && audio.audio_ready));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (!fifo_empty) begin
                        data_reg  <= fifo_head;
                        valid_reg <= 1'b1;
                        state     <= ST_LOAD;
                    end
                end
                default: begin
                    if (audio.audio_ready) begin
                        if (!fifo_empty) begin
                            data_reg <= fifo_head;
                        end else begin
                            valid_reg <= 1'b0;
                            state     <= ST_EMPTY;
                        end
                    end
                end
            endcase
        end
    end

    assign audio.audio_data  = data_reg;
    assign audio.audio_valid = valid_reg;

    // Stall one entry early because the flag itself is a cycle late.
    always_ff @(posedge clk) begin
        if (rst) begin
            sim_stall <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            sim_stall <= (fifo_count >= CW'(FIFO_DEPTH - 1));
            if (step_done && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_drum_audio_tap.sv
// Directed bench for drum_audio_tap: unity-gain and x8-gain instances share the simulator inputs.
module tb_drum_audio_tap;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [17:0] u_np1_ij;
    logic [5:0]         row;
    logic               u_valid;
    logic               step_done;
    logic               sim_stall0, overflow0;
    logic               sim_stall1, overflow1;

    int checkCount = 0;
    int passCount  = 0;

    drum_audio_tap_if bus0 ();
    drum_audio_tap_if bus1 ();

    drum_audio_tap #(.GAIN_SHIFT(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .u_np1_ij  (u_np1_ij),
        .row       (row),
        .u_valid   (u_valid),
        .step_done (step_done),
        .audio     (bus0.master),
        .sim_stall (sim_stall0),
        .overflow  (overflow0)
    );

    drum_audio_tap #(.GAIN_SHIFT(3)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .u_np1_ij  (u_np1_ij),
        .row       (row),
        .u_valid   (u_valid),
        .step_done (step_done),
        .audio     (bus1.master),
        .sim_stall (sim_stall1),
        .overflow  (overflow1)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end else begin
            passCount++;
        end
    endtask

    // Drive one cycle of simulator inputs, then settle just after the edge.
    task automatic applyStimulus(input logic [17:0] u, input logic [5:0] r, input logic uv, input logic sd);
        u_np1_ij  = u;
        row       = r;
        u_valid   = uv;
        step_done = sd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(18'h0, 6'd0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        u_np1_ij = '0;
        row = '0;
        u_valid = 1'b0;
        step_done = 1'b0;
        bus0.audio_ready = 1'b0;
        bus1.audio_ready = 1'b1;
        idle();
        idle();
        checkOutput("rst_valid", 32'(bus0.audio_valid), 32'd0);
        checkOutput("rst_data", 32'(bus0.audio_data), 32'h0);
        checkOutput("rst_stall", 32'(sim_stall0), 32'd0);
        checkOutput("rst_ovf", 32'(overflow0), 32'd0);
        rst = 1'b0;

        // T1: capture then step_done, 2-edge latency
        applyStimulus(18'h04000, 6'd16, 1'b1, 1'b0);
        checkOutput("t1_capture_no_valid", 32'(bus0.audio_valid), 32'd0);
        applyStimulus(18'h0, 6'd0, 1'b0, 1'b1);
        checkOutput("t1_edge_k", 32'(bus0.audio_valid), 32'd0);
        idle();
        checkOutput("t1_valid_k1", 32'(bus0.audio_valid), 32'd1);
        checkOutput("t1_data", 32'(bus0.audio_data), 32'h1000);
        bus0.audio_ready = 1'b1;
        idle();
        checkOutput("t1_valid_drop", 32'(bus0.audio_valid), 32'd0);

        // T2: gain x8 on dut1, saturation both ways plus in-range values
        applyStimulus(18'h10000, 6'd16, 1'b1, 1'b1);
        idle();
        checkOutput("t2_sat_pos", 32'(bus1.audio_data), 32'h7FFF);
        idle();
        applyStimulus(18'h30000, 6'd16, 1'b1, 1'b1);
        idle();
        checkOutput("t2_sat_neg", 32'(bus1.audio_data), 32'h8000);
        idle();
        applyStimulus(18'h00100, 6'd16, 1'b1, 1'b1);
        idle();
        checkOutput("t2_pos_inrange", 32'(bus1.audio_data), 32'h0200);
        idle();
        applyStimulus(18'h3FF00, 6'd16, 1'b1, 1'b1);
        idle();
        checkOutput("t2_neg_inrange", 32'(bus1.audio_data), 32'hFE00);
        checkOutput("t2_valid", 32'(bus1.audio_valid), 32'd1);
        idle();

        // T5: bypass, then foreign rows must not disturb tap_reg or the output
        applyStimulus(18'h08000, 6'd16, 1'b1, 1'b1);
        idle();
        checkOutput("t5_bypass", 32'(bus0.audio_data), 32'h2000);
        idle();
        checkOutput("t5_drained", 32'(bus0.audio_valid), 32'd0);
        applyStimulus(18'h1FFFF, 6'd15, 1'b1, 1'b0);
        applyStimulus(18'h1FFFF, 6'd17, 1'b1, 1'b0);
        applyStimulus(18'h1FFFF, 6'd40, 1'b1, 1'b0);
        checkOutput("t5_other_rows_no_valid", 32'(bus0.audio_valid), 32'd0);
        applyStimulus(18'h0, 6'd0, 1'b0, 1'b1);
        idle();
        checkOutput("t5_tap_held", 32'(bus0.audio_data), 32'h2000);
        idle();

        // T4: streaming one sample per cycle with ready high
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(18'(i * 32'h800), 6'd16, 1'b1, 1'b1);
            if (i >= 2) begin
                checkOutput($sformatf("t4_data_%0d", i - 1), 32'(bus0.audio_data), 32'((i - 1) * 32'h200));
                checkOutput($sformatf("t4_stall_%0d", i), 32'(sim_stall0), 32'd0);
            end
        end
        idle();
        checkOutput("t4_data_6", 32'(bus0.audio_data), 32'h0C00);
        idle();
        checkOutput("t4_end_valid", 32'(bus0.audio_valid), 32'd0);

        // T3: fill with ready low; output register holds sample 1, FIFO the next 8
        rst = 1'b1;
        idle();
        rst = 1'b0;
        bus0.audio_ready = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            applyStimulus(18'(n * 32'h400), 6'd16, 1'b1, 1'b1);
            if (n == 8) checkOutput("t3_stall_n8", 32'(sim_stall0), 32'd0);
            if (n == 9) begin
                checkOutput("t3_stall_n9", 32'(sim_stall0), 32'd1);
                checkOutput("t3_ovf_n9", 32'(overflow0), 32'd0);
            end
            if (n == 10) checkOutput("t3_ovf_n10", 32'(overflow0), 32'd1);
        end
        idle();
        checkOutput("t3_head_hold", 32'(bus0.audio_data), 32'h0100);
        bus0.audio_ready = 1'b1;
        for (int k = 2; k <= 9; k++) begin
            idle();
            checkOutput($sformatf("t3_drain_%0d", k), 32'(bus0.audio_data), 32'(k * 32'h100));
        end
        idle();
        checkOutput("t3_no_dropped_sample", 32'(bus0.audio_valid), 32'd0);
        checkOutput("t3_stall_cleared", 32'(sim_stall0), 32'd0);
        checkOutput("t3_ovf_sticky", 32'(overflow0), 32'd1);

        // T6: reset with samples queued and valid high
        bus0.audio_ready = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            applyStimulus(18'(n * 32'h1000), 6'd16, 1'b1, 1'b1);
        end
        checkOutput("t6_pre_valid", 32'(bus0.audio_valid), 32'd1);
        rst = 1'b1;
        idle();
        checkOutput("t6_rst_valid", 32'(bus0.audio_valid), 32'd0);
        checkOutput("t6_rst_stall", 32'(sim_stall0), 32'd0);
        checkOutput("t6_rst_ovf", 32'(overflow0), 32'd0);
        checkOutput("t6_rst_data", 32'(bus0.audio_data), 32'h0);
        rst = 1'b0;
        bus0.audio_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            idle();
            checkOutput($sformatf("t6_no_stale_%0d", k), 32'(bus0.audio_valid), 32'd0);
        end
        applyStimulus(18'h0, 6'd0, 1'b0, 1'b1);
        idle();
        checkOutput("t6_tap_cleared_valid", 32'(bus0.audio_valid), 32'd1);
        checkOutput("t6_tap_cleared_data", 32'(bus0.audio_data), 32'h0);
        idle();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
